// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the RV64 instruction encoder and the control
// decoder bench: symbolic op codes, RISC-V opcode/funct fields and the
// immediate range limits used by the encoder's error checks.
// ---------------------------------------------------------------------------
package enc_pkg;

  typedef enum logic [2:0] {
    OP_BEQ     = 3'd0,
    OP_LD      = 3'd1,
    OP_SD      = 3'd2,
    OP_ADD     = 3'd3,
    OP_SUB     = 3'd4,
    OP_AND     = 3'd5,
    OP_OR      = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  // Major opcodes
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  // funct3 / funct7 fields
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_LD     = 3'b011;
  localparam logic [2:0] F3_SD     = 3'b011;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  // Immediate limits (byte offsets)
  localparam int IMM_W     = 13;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int BIMM_MIN  = -4096;
  localparam int BIMM_MAX  = 4094;

endpackage

// File: rtl/instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
// Purely combinational packer: turns a symbolic request into a 32-bit RV64
// instruction word and flags whether the immediate is outside the range the
// chosen format can represent. Whether that flag matters is decided by the
// encoder top level.
//
// Ports:
//   i_op          symbolic operation (op_e)
//   i_rd/rs1/rs2  register indices
//   i_imm         13-bit signed byte offset
//   o_instr       packed instruction word (unused fields zero)
//   o_range_err   immediate out of range / misaligned for this op
// ---------------------------------------------------------------------------
module instr_pack
  import enc_pkg::*;
(
  input  op_e               i_op,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [IMM_W-1:0]  i_imm,
  output logic [31:0]       o_instr,
  output logic              o_range_err
);

  logic signed [31:0] w_immVal;
  logic               w_imm12Bad;
  logic               w_bImmBad;

  assign w_immVal   = {{(32-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign w_imm12Bad = (w_immVal < IMM12_MIN) || (w_immVal > IMM12_MAX);
  // Branch offsets must also be halfword aligned since imm[0] is not encoded.
  assign w_bImmBad  = (w_immVal < BIMM_MIN) || (w_immVal > BIMM_MAX) || i_imm[0];

  always_comb begin
    o_instr     = '0;
    o_range_err = 1'b0;
    case (i_op)
      OP_BEQ: begin
        o_instr     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                       i_imm[4:1], i_imm[11], OPC_BRANCH};
        o_range_err = w_bImmBad;
      end
      OP_LD: begin
        o_instr     = {i_imm[11:0], i_rs1, F3_LD, i_rd, OPC_LOAD};
        o_range_err = w_imm12Bad;
      end
      OP_SD: begin
        o_instr     = {i_imm[11:5], i_rs2, i_rs1, F3_SD, i_imm[4:0], OPC_STORE};
        o_range_err = w_imm12Bad;
      end
      OP_ADD: o_instr = {F7_BASE, i_rs2, i_rs1, F3_ADDSUB, i_rd, OPC_OP};
      OP_SUB: o_instr = {F7_SUB,  i_rs2, i_rs1, F3_ADDSUB, i_rd, OPC_OP};
      OP_AND: o_instr = {F7_BASE, i_rs2, i_rs1, F3_AND,    i_rd, OPC_OP};
      OP_OR:  o_instr = {F7_BASE, i_rs2, i_rs1, F3_OR,     i_rd, OPC_OP};
      // Unassigned op packs as a harmless nop (addi x0,x0,0).
      default: o_instr = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OPIMM};
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Streaming RV64 instruction encoder. Accepts symbolic requests over a
// valid/ready handshake and emits packed instruction words, each tagged with
// a sequential instruction-memory word address, through a single output
// holding register.
//
// Configuration macro: INSTR_ENCODER_CHECK_EN
//   defined   - illegal ops and bad immediates are consumed without output
//               and raise the sticky o_err_illegal / o_err_imm flags.
//   undefined - no checks; immediates truncate, op 7 emits a nop, both
//               error flags stay 0.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i_clear                     synchronous flush (priority over everything)
//   i_in_valid / o_in_ready     request handshake
//   i_in_op, i_in_rd/rs1/rs2    symbolic request fields
//   i_in_imm                    13-bit signed byte offset
//   o_out_valid / i_out_ready   output handshake
//   o_out_instr, o_out_addr     encoded word and its word address
//   o_err_illegal, o_err_imm    sticky error flags
//   o_wrapped                   sticky: address counter wrapped
// ---------------------------------------------------------------------------
module instr_encoder
  import enc_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [2:0]        i_in_op,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [IMM_W-1:0]  i_in_imm,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_instr,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_err_illegal,
  output logic              o_err_imm,
  output logic              o_wrapped
);

  op_e               w_op;
  logic [31:0]       w_word;
  logic              w_rangeErr;
  logic              w_opIllegal;
  logic              w_badIllegal;
  logic              w_badImm;
  logic              w_accept;
  logic              w_emit;

  logic              r_outValid;
  logic [31:0]       r_outInstr;
  logic [ADDR_W-1:0] r_outAddr;
  logic [ADDR_W-1:0] r_nextAddr;
  logic              r_errIllegal;
  logic              r_errImm;
  logic              r_wrapped;

  assign w_op        = op_e'(i_in_op);
  assign w_opIllegal = (w_op == OP_ILLEGAL);

  instr_pack u_pack (
    .i_op        (w_op),
    .i_rd        (i_in_rd),
    .i_rs1       (i_in_rs1),
    .i_rs2       (i_in_rs2),
    .i_imm       (i_in_imm),
    .o_instr     (w_word),
    .o_range_err (w_rangeErr)
  );

`ifdef INSTR_ENCODER_CHECK_EN
  assign w_badIllegal = w_opIllegal;
  assign w_badImm     = w_rangeErr && !w_opIllegal;
`else
  logic w_unusedChecks;
  assign w_unusedChecks = w_rangeErr ^ w_opIllegal;
  assign w_badIllegal   = 1'b0;
  assign w_badImm       = 1'b0;
`endif

  // A held word that drains this cycle frees the register for a new one.
  assign o_in_ready = !i_clear && (!r_outValid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  // Faulty requests complete the handshake but never reach the output.
  assign w_emit     = w_accept && !w_badIllegal && !w_badImm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid   <= 1'b0;
      r_outInstr   <= '0;
      r_outAddr    <= BASE_ADDR;
      r_nextAddr   <= BASE_ADDR;
      r_errIllegal <= 1'b0;
      r_errImm     <= 1'b0;
      r_wrapped    <= 1'b0;
    end else if (i_clear) begin
      r_outValid   <= 1'b0;
      r_outAddr    <= BASE_ADDR;
      r_nextAddr   <= BASE_ADDR;
      r_errIllegal <= 1'b0;
      r_errImm     <= 1'b0;
      r_wrapped    <= 1'b0;
    end else begin
      if (r_outValid && i_out_ready) begin
        r_outValid <= 1'b0;
      end
      if (w_emit) begin
        r_outValid <= 1'b1;
        r_outInstr <= w_word;
        r_outAddr  <= r_nextAddr;
        r_nextAddr <= r_nextAddr + ADDR_W'(1);
        if (&r_nextAddr) begin
          r_wrapped <= 1'b1;
        end
      end
      if (w_accept && w_badIllegal) begin
        r_errIllegal <= 1'b1;
      end
      if (w_accept && w_badImm) begin
        r_errImm <= 1'b1;
      end
    end
  end

  assign o_out_valid   = r_outValid;
  assign o_out_instr   = r_outInstr;
  assign o_out_addr    = r_outAddr;
  assign o_err_illegal = r_errIllegal;
  assign o_err_imm     = r_errImm;
  assign o_wrapped     = r_wrapped;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Drives two encoders (8-bit and 2-bit address) with identical requests and
// compares them every cycle against a transaction-level reference model
// built from the RISC-V field layouts, plus directed known-good words.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

`ifdef INSTR_ENCODER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        inValid;
  logic [2:0]  inOp;
  logic [4:0]  inRd, inRs1, inRs2;
  logic [12:0] inImm;
  logic        outReady;

  logic        readyA, validA, illA, immA, wrapA;
  logic [31:0] instrA;
  logic [7:0]  addrA;
  logic        readyB, validB, illB, immB, wrapB;
  logic [31:0] instrB;
  logic [1:0]  addrB;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dutA (
    .clk(clk), .rst_n(rst_n), .i_clear(clear),
    .i_in_valid(inValid), .o_in_ready(readyA), .i_in_op(inOp),
    .i_in_rd(inRd), .i_in_rs1(inRs1), .i_in_rs2(inRs2), .i_in_imm(inImm),
    .o_out_valid(validA), .i_out_ready(outReady), .o_out_instr(instrA),
    .o_out_addr(addrA), .o_err_illegal(illA), .o_err_imm(immA),
    .o_wrapped(wrapA)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dutB (
    .clk(clk), .rst_n(rst_n), .i_clear(clear),
    .i_in_valid(inValid), .o_in_ready(readyB), .i_in_op(inOp),
    .i_in_rd(inRd), .i_in_rs1(inRs1), .i_in_rs2(inRs2), .i_in_imm(inImm),
    .o_out_valid(validB), .i_out_ready(outReady), .o_out_instr(instrB),
    .o_out_addr(addrB), .o_err_illegal(illB), .o_err_imm(immB),
    .o_wrapped(wrapB)
  );

  typedef struct {
    bit        valid;
    bit [31:0] instr;
    int        addr;
    int        nextAddr;
    bit        errIll;
    bit        errImm;
    bit        wrapped;
  } model_t;

  model_t mA, mB;
  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference encoding assembled field by field from the ISA formats.
  function automatic bit [31:0] refEncode(int op, int rd, int rs1, int rs2, int imm);
    int u;
    int w;
    u = imm & 'h1fff;
    case (op)
      0: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3f) << 25) | (rs2 << 20) |
             (rs1 << 15) | (((u >> 1) & 'hf) << 8) | (((u >> 11) & 1) << 7) | 'h63;
      1: w = ((u & 'hfff) << 20) | (rs1 << 15) | (3 << 12) | (rd << 7) | 'h03;
      2: w = (((u >> 5) & 'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (3 << 12) |
             ((u & 'h1f) << 7) | 'h23;
      3: w = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33;
      4: w = ('h20 << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33;
      5: w = (rs2 << 20) | (rs1 << 15) | (7 << 12) | (rd << 7) | 'h33;
      6: w = (rs2 << 20) | (rs1 << 15) | (6 << 12) | (rd << 7) | 'h33;
      default: w = 'h13;
    endcase
    return 32'(w);
  endfunction

  function automatic bit immBad(int op, int imm);
    if (!CHECK_EN) return 1'b0;
    if (op == 1 || op == 2) return (imm < -2048) || (imm > 2047);
    if (op == 0) return (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
    return 1'b0;
  endfunction

  function automatic model_t modelReset();
    model_t m;
    m.valid = 1'b0; m.instr = '0; m.addr = 0; m.nextAddr = 0;
    m.errIll = 1'b0; m.errImm = 1'b0; m.wrapped = 1'b0;
    return m;
  endfunction

  // Predicts the state after the next rising edge from the current inputs.
  function automatic model_t modelStep(model_t m, int w);
    model_t n;
    bit ready;
    int op, imm;
    n     = m;
    ready = !clear && (!m.valid || outReady);
    op    = int'(inOp);
    imm   = int'(signed'(inImm));
    if (clear) return modelReset();
    if (m.valid && outReady) n.valid = 1'b0;
    if (inValid && ready) begin
      if (CHECK_EN && op == 7) begin
        n.errIll = 1'b1;
      end else if (immBad(op, imm)) begin
        n.errImm = 1'b1;
      end else begin
        n.valid = 1'b1;
        n.instr = refEncode(op, int'(inRd), int'(inRs1), int'(inRs2), imm);
        n.addr  = m.nextAddr;
        if (m.nextAddr == (1 << w) - 1) n.wrapped = 1'b1;
        n.nextAddr = (m.nextAddr + 1) % (1 << w);
      end
    end
    return n;
  endfunction

  task automatic checkModel(input string name, input model_t m, input logic v,
                            input logic [31:0] instr, input logic [31:0] addr,
                            input logic ill, input logic imm, input logic wrap,
                            input logic rdy);
    checkOutput({name, "_valid"}, 32'(v), 32'(m.valid));
    if (m.valid) begin
      checkOutput({name, "_instr"}, instr, m.instr);
      checkOutput({name, "_addr"}, addr, m.addr);
    end
    checkOutput({name, "_errIll"}, 32'(ill), 32'(m.errIll));
    checkOutput({name, "_errImm"}, 32'(imm), 32'(m.errImm));
    checkOutput({name, "_wrapped"}, 32'(wrap), 32'(m.wrapped));
    if (rst_n)
      checkOutput({name, "_inReady"}, 32'(rdy), 32'(!clear && (!m.valid || outReady)));
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      mA = modelReset();
      mB = modelReset();
    end
    checkModel("A", mA, validA, instrA, 32'(addrA), illA, immA, wrapA, readyA);
    checkModel("B", mB, validB, instrB, 32'(addrB), illB, immB, wrapB, readyB);
    if (rst_n) begin
      mA = modelStep(mA, 8);
      mB = modelStep(mB, 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setInputs(input bit v, input int op, input int rd, input int rs1,
                           input int rs2, input int imm, input bit rdy, input bit clr);
    inValid  = v;
    inOp     = op[2:0];
    inRd     = rd[4:0];
    inRs1    = rs1[4:0];
    inRs2    = rs2[4:0];
    inImm    = imm[12:0];
    outReady = rdy;
    clear    = clr;
  endtask

  task automatic applyStimulus(input bit v, input int op, input int rd, input int rs1,
                               input int rs2, input int imm, input bit rdy, input bit clr);
    setInputs(v, op, rd, rs1, rs2, imm, rdy, clr);
    tick();
  endtask

  initial begin
    int picks[8];
    int imm, sel;
    picks = '{-4096, -4095, -2049, -2048, 2047, 2048, 4094, 4095};
    mA = modelReset();
    mB = modelReset();
    rst_n = 1'b0;
    setInputs(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(validA), 32'd0);
    checkOutput("reset_instr", instrA, 32'd0);
    checkOutput("reset_addr", 32'(addrA), 32'd0);
    checkOutput("reset_flags", {29'd0, illA, immA, wrapA}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_inReady", 32'(readyA), 32'd1);

    // Known-good words from the decoder's stimulus set
    applyStimulus(1, 0, 0, 1, 2, 40, 1, 0);
    checkOutput("beq_word", instrA, 32'h02208463);
    checkOutput("beq_addr", 32'(addrA), 32'd0);
    applyStimulus(1, 1, 1, 2, 0, 40, 1, 0);
    checkOutput("ld_word", instrA, 32'h02813083);
    checkOutput("ld_addr", 32'(addrA), 32'd1);
    applyStimulus(1, 2, 0, 2, 1, 40, 1, 0);
    checkOutput("sd_word", instrA, 32'h02113423);
    checkOutput("sd_addr", 32'(addrA), 32'd2);
    applyStimulus(1, 3, 3, 1, 2, 0, 1, 0);
    checkOutput("add_word", instrA, 32'h002081B3);
    checkOutput("add_addr", 32'(addrA), 32'd3);
    checkOutput("wrapB_after4", 32'(wrapB), 32'd1);
    checkOutput("wrapA_after4", 32'(wrapA), 32'd0);

    // Consumer stalls: request must wait, output must hold
    for (int i = 0; i < 3; i++) begin
      setInputs(1, 1, 5, 6, 0, 8, 0, 0);
      #1;
      checkOutput("stall_inReady", 32'(readyA), 32'd0);
      tick();
      checkOutput("stall_hold", instrA, 32'h002081B3);
    end
    applyStimulus(1, 1, 5, 6, 0, 8, 1, 0);
    checkOutput("release_word", instrA, 32'h00833283);
    checkOutput("release_addrA", 32'(addrA), 32'd4);
    checkOutput("release_addrB", 32'(addrB), 32'd0);

    // Out-of-range / misaligned immediates and the illegal op
    applyStimulus(1, 1, 1, 2, 0, 2048, 1, 0);
    applyStimulus(1, 0, 0, 1, 2, 41, 1, 0);
    applyStimulus(1, 7, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("err_imm", 32'(immA), 32'(CHECK_EN));
    checkOutput("err_illegal", 32'(illA), 32'(CHECK_EN));
    checkOutput("err_addr", 32'(addrA), CHECK_EN ? 32'd4 : 32'd7);

    // clear while a word is held and a request is pending
    applyStimulus(1, 3, 3, 1, 2, 0, 0, 0);
    setInputs(1, 4, 9, 10, 11, 0, 1, 1);
    #1;
    checkOutput("clear_inReady", 32'(readyA), 32'd0);
    tick();
    checkOutput("clear_valid", 32'(validA), 32'd0);
    checkOutput("clear_addr", 32'(addrA), 32'd0);
    checkOutput("clear_flags", {29'd0, illA, immA, wrapA}, 32'd0);
    applyStimulus(1, 4, 9, 10, 11, 0, 1, 0);
    checkOutput("after_clear_addr", 32'(addrA), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      imm = int'($urandom_range(0, 200)) - 100;
      else if (sel == 1) imm = int'($urandom_range(0, 8191)) - 4096;
      else               imm = picks[$urandom_range(0, 7)];
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), imm,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset in the middle of a stalled word
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 5, 4, 3, 2, 0, 0, 0);
    applyStimulus(1, 6, 7, 8, 9, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(validA), 32'd0);
    checkOutput("async_instr", instrA, 32'd0);
    checkOutput("async_addr", 32'(addrA), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      applyStimulus(1, i % 7, i, i + 1, i + 2, 2 * i, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV64 instruction encoder: the write-side counterpart of the `control` decoder. It accepts symbolic instruction requests (op, register indices, immediate) over a valid/ready handshake and emits packed 32-bit instruction words, each tagged with a sequential instruction-memory word address. It sits between the bench/loader and instruction memory. The same block generates the stimulus words that the decoder consumes (e.g. 0x02208463, 0x02813083, 0x02113423).

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width.
- `BASE_ADDR`, 0: address loaded on reset and on `clear`.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous flush: drops the held word, reloads the address, clears error flags.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_op`  in  3  `op_e`: BEQ=0, LD=1, SD=2, ADD=3, SUB=4, AND=5, OR=6; 7 is illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  13  signed immediate (byte offset).
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `out_instr`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  word address of `out_instr`.
- `err_illegal`  out  1  sticky: an illegal op was seen.
- `err_imm`  out  1  sticky: an immediate was out of range or misaligned.
- `wrapped`  out  1  sticky: the address counter wrapped.

## Operation
- Single output holding register with state EMPTY/FULL, stored as `out_valid`.
- `in_ready = !clear && (!out_valid || out_ready)`. A new word may be accepted in the same cycle the held word drains.
- Encodings:
  - BEQ: opcode 1100011, f3 000, B-format from `imm[12:1]`.
  - LD: opcode 0000011, f3 011, I-format `imm[11:0]`, rd.
  - SD: opcode 0100011, f3 011, S-format.
  - R-type: opcode 0110011. ADD f3 000/f7 0000000; SUB f3 000/f7 0100000; AND f3 111; OR f3 110.
- Unused fields are zero.
- Range rules:
  - LD/SD: `imm` must be in −2048..2047.
  - BEQ: `imm` must be in −4096..4094 and even.
  - R-type: `imm` is ignored.
- A request with an error is consumed: `in_ready` handshake completes, no word is emitted, the address does not advance, and the sticky flag is set.
- The address counter starts at `BASE_ADDR` and increments by 1 per emitted word. It wraps modulo 2^ADDR_W; on wrap (incrementing from all-ones) it sets `wrapped`.
- `clear` has priority over everything in the same cycle:
  - `out_valid` ← 0, address ← `BASE_ADDR`, all sticky flags ← 0.
  - No request is accepted; a pending output handshake is discarded.
- Reset mid-operation: same effect as `clear`, applied asynchronously.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=BASE_ADDR, `err_illegal`=`err_imm`=`wrapped`=0. `in_ready`=1 once `rst_n` is high and `clear` is low.
- Latency: the word appears on `out_*` 1 cycle after acceptance.
- Throughput: 1 word/cycle while `out_ready`=1.
- `out_instr`/`out_addr` hold stable while `out_valid && !out_ready`.
- Sticky flags update 1 cycle after the offending acceptance.

## Configuration
- Macro: `INSTR_ENCODER_CHECK_EN`.
- Defined: range, alignment and illegal-op checks are active as above.
- Undefined:
  - `err_illegal`/`err_imm` are tied to 0.
  - Immediates are truncated to the field width with no checks; BEQ drops `imm[0]`.
  - op 7 encodes as `addi x0,x0,0` (0x00000013) and is emitted normally.

## Structure
- Package `enc_pkg`: `op_e`, opcode/funct3/funct7 localparams, immediate range constants. Shared with the `control` testbench.
- Sub-module `instr_pack`: purely combinational; (op, rd, rs1, rs2, imm) → 32-bit word plus a range-error bit.
- Top level: handshake, address counter, sticky flags.

## Test plan
- Reset, then BEQ rs1=1 rs2=2 imm=40 with `out_ready`=1 → next cycle `out_instr`=0x02208463, `out_addr`=0.
- Back-to-back LD rd=1 rs1=2 imm=40, then SD rs2=1 rs1=2 imm=40, then ADD rd=3 rs1=1 rs2=2 → 0x02813083 @1, 0x02113423 @2, 0x002081B3 @3, one per cycle.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and the output is stable; release → drains, then the next request is accepted.
- LD imm=2048; BEQ imm=41; op=7 → no output, address unchanged, `err_imm`=1, `err_illegal`=1. Same stimulus with the macro undefined → 3 words emitted, flags stay 0.
- `ADDR_W`=2: emit 5 words → addresses 0,1,2,3,0 and `wrapped`=1 after the 4th.
- Assert `clear` while `out_valid`=1 and `in_valid`=1 → next cycle `out_valid`=0, address=BASE_ADDR, flags 0, request not consumed. Async `rst_n` drop mid-stream → outputs go to reset values immediately.
